next_state_decoder: RTL and testbench



---
 rtl/cu_pkg.sv | 51 +++++
 rtl/moc_timer.sv | 31 +++
 rtl/next_state_decoder.sv | 132 +++++++++++++
 tb/tb_next_state_decoder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the ARM-subset control unit: microstate codes,
// IR field positions and small decode helpers.
package cu_pkg;

    typedef enum logic [6:0] {
        S_RESET      = 7'd0,
        S_FETCH_ADDR = 7'd1,
        S_FETCH_INC  = 7'd2,
        S_FETCH_WAIT = 7'd3,
        S_DECODE     = 7'd4,
        S_DP_IMM     = 7'd6,
        S_DP_SHIFT   = 7'd7,
        S_BL         = 7'd9,
        S_B          = 7'd10,
        S_PRE_ADDR   = 7'd33,
        S_LD_START   = 7'd34,
        S_LD_WAIT    = 7'd35,
        S_LD_WB      = 7'd36,
        S_POST_ADDR  = 7'd37,
        S_WB_PRE     = 7'd38,
        S_WB_POST    = 7'd39,
        S_ST_MDR     = 7'd40,
        S_ST_START   = 7'd41,
        S_ST_WAIT    = 7'd42
    } cu_state_e;

    localparam int COND_HI  = 31;
    localparam int L_BIT    = 20;
    localparam int W_BIT    = 21;
    localparam int P_BIT    = 24;
    localparam int I_BIT    = 25;
    localparam int LINK_BIT = 24;

    function automatic logic is_wait(input cu_state_e s);
        return (s == S_FETCH_WAIT) || (s == S_LD_WAIT) || (s == S_ST_WAIT);
    endfunction

    // Base-register writeback after a load/store: pre-indexed only with W set.
    function automatic cu_state_e wb_target(input logic [31:0] ir_v);
        cu_state_e r;
        if (ir_v[P_BIT] && ir_v[W_BIT]) begin
            r = S_WB_PRE;
        end else if (!ir_v[P_BIT]) begin
            r = S_WB_POST;
        end else begin
            r = S_FETCH_ADDR;
        end
        return r;
    endfunction

endpackage

// File: rtl/moc_timer.sv
// Counts cycles spent waiting for memory completion; flags the last
// permitted wait cycle.
module moc_timer #(
    parameter int MOC_TIMEOUT = 16,
    parameter int TW          = 5
) (
    input  logic CLK,
    input  logic CLR,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TW-1:0] LAST = TW'(MOC_TIMEOUT - 1);

    logic [TW-1:0] cnt_r;

    // Wait-cycle counter, restarted on every state change.
    always_ff @(posedge CLK) begin
        if (CLR || clear) begin
            cnt_r <= {TW{1'b0}};
        end else if (enable) begin
            cnt_r <= cnt_r + TW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == LAST);

endmodule

// File: rtl/next_state_decoder.sv
// Microsequencer for the ARM-subset CPU: holds the microstate and picks the
// next one from the IR, the condition result and memory completion.
module next_state_decoder
    import cu_pkg::*;
#(
    parameter int MOC_TIMEOUT = 16,
    parameter int TW          = 5
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [31:0] ir,
    input  logic        cond,
    input  logic        moc,
    output logic [6:0]  state,
    output logic        bus_err,
    output logic        illegal
);

    cu_state_e state_r;
    cu_state_e nxt_s;
    logic      bus_err_r;
    logic      illegal_r;
    logic      ill_set_s;
    logic      timeout_s;
    logic      expired_s;
    logic      tmr_clr_s;
    logic      tmr_en_s;
    logic      ir_unused_s;

    assign tmr_clr_s   = (nxt_s != state_r);
    assign tmr_en_s    = is_wait(state_r) && !moc;
    assign ir_unused_s = ^{ir[COND_HI:28], ir[23:22], ir[19:5], ir[3:0]};

    moc_timer #(
        .MOC_TIMEOUT (MOC_TIMEOUT),
        .TW          (TW)
    ) u_moc_timer (
        .CLK     (CLK),
        .CLR     (CLR),
        .clear   (tmr_clr_s),
        .enable  (tmr_en_s),
        .expired (expired_s)
    );

    // Next-state selection, illegal detection and timeout abort.
    always_comb begin
        nxt_s     = S_FETCH_ADDR;
        ill_set_s = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            S_RESET:      nxt_s = S_FETCH_ADDR;
            S_FETCH_ADDR: nxt_s = S_FETCH_INC;
            S_FETCH_INC:  nxt_s = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                if (moc) begin
                    nxt_s = S_DECODE;
                end else if (expired_s) begin
                    nxt_s     = S_RESET;
                    timeout_s = 1'b1;
                end else begin
                    nxt_s = S_FETCH_WAIT;
                end
            end
            S_DECODE: begin
                if (!cond) begin
                    nxt_s = S_FETCH_ADDR;
                end else if (ir[27:25] == 3'b101) begin
                    nxt_s = ir[LINK_BIT] ? S_BL : S_B;
                end else if ((ir[27:26] == 2'b00) && ir[I_BIT]) begin
                    nxt_s = S_DP_IMM;
                end else if ((ir[27:26] == 2'b00) && !ir[4]) begin
                    nxt_s = S_DP_SHIFT;
                end else if (ir[27:26] == 2'b01) begin
                    nxt_s = ir[P_BIT] ? S_PRE_ADDR : S_POST_ADDR;
                end else begin
                    nxt_s     = S_FETCH_ADDR;
                    ill_set_s = 1'b1;
                end
            end
            S_DP_IMM, S_DP_SHIFT, S_BL, S_B, S_WB_PRE, S_WB_POST:
                nxt_s = S_FETCH_ADDR;
            S_PRE_ADDR, S_POST_ADDR:
                nxt_s = ir[L_BIT] ? S_LD_START : S_ST_MDR;
            S_LD_START:   nxt_s = S_LD_WAIT;
            S_LD_WAIT: begin
                if (moc) begin
                    nxt_s = S_LD_WB;
                end else if (expired_s) begin
                    nxt_s     = S_RESET;
                    timeout_s = 1'b1;
                end else begin
                    nxt_s = S_LD_WAIT;
                end
            end
            S_LD_WB:      nxt_s = wb_target(ir);
            S_ST_MDR:     nxt_s = S_ST_START;
            S_ST_START:   nxt_s = S_ST_WAIT;
            S_ST_WAIT: begin
                if (moc) begin
                    nxt_s = wb_target(ir);
                end else if (expired_s) begin
                    nxt_s     = S_RESET;
                    timeout_s = 1'b1;
                end else begin
                    nxt_s = S_ST_WAIT;
                end
            end
            default: begin
                nxt_s     = S_FETCH_ADDR;
                ill_set_s = 1'b1;
            end
        endcase
    end

    // State register with registered status flags; CLR wins over everything.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_r   <= S_RESET;
            bus_err_r <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= nxt_s;
            bus_err_r <= timeout_s;
            illegal_r <= illegal_r | ill_set_s;
        end
    end

    assign state   = state_r;
    assign bus_err = bus_err_r;
    assign illegal = illegal_r;

endmodule

// File: tb/tb_next_state_decoder.sv
// Self-checking bench for next_state_decoder: route-based reference model
// checked every cycle, plus literal state traces per instruction.
module tb_next_state_decoder;

    localparam int MOC_TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic [31:0] ir = 32'h0;
    logic        cond = 1'b0;
    logic        moc = 1'b0;
    logic [6:0]  state;
    logic        bus_err;
    logic        illegal;

    next_state_decoder #(.MOC_TIMEOUT(MOC_TIMEOUT), .TW(5)) dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .ir      (ir),
        .cond    (cond),
        .moc     (moc),
        .state   (state),
        .bus_err (bus_err),
        .illegal (illegal)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: the upcoming microstates are kept as a route queue
    int m_state = 0;
    int m_wait  = 0;
    bit m_bus   = 1'b0;
    bit m_ill   = 1'b0;
    bit m_valid = 1'b0;
    int route[$];

    int trace[$];
    int bus_cnt   = 0;
    int fetch_lat = 0;
    int mem_lat   = 0;
    int wcnt      = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic push_fetch();
        route.push_back(1); route.push_back(2); route.push_back(3); route.push_back(4);
    endtask

    task automatic plan_instr();
        bit pre;
        route.delete();
        if (!cond) begin
        end else if (ir[27:25] == 3'b101) begin
            route.push_back(ir[24] ? 9 : 10);
        end else if (ir[27:26] == 2'b00 && ir[25]) begin
            route.push_back(6);
        end else if (ir[27:26] == 2'b00 && !ir[4]) begin
            route.push_back(7);
        end else if (ir[27:26] == 2'b01) begin
            pre = ir[24];
            route.push_back(pre ? 33 : 37);
            if (ir[20]) begin
                route.push_back(34); route.push_back(35); route.push_back(36);
            end else begin
                route.push_back(40); route.push_back(41); route.push_back(42);
            end
            if (pre && ir[21]) route.push_back(38);
            else if (!pre) route.push_back(39);
        end else begin
            m_ill = 1'b1;
        end
        push_fetch();
    endtask

    // Model update on each edge, then compare with the DUT just after it.
    always @(posedge CLK) begin
        m_bus = 1'b0;
        if (CLR) begin
            m_valid = 1'b1; m_state = 0; m_ill = 1'b0; m_wait = 0;
            route.delete(); push_fetch();
        end else if (m_valid) begin
            if (m_state == 3 || m_state == 35 || m_state == 42) begin
                if (moc) begin
                    m_state = route.pop_front(); m_wait = 0;
                end else if (m_wait == MOC_TIMEOUT - 1) begin
                    m_state = 0; m_bus = 1'b1; m_wait = 0;
                    route.delete(); push_fetch();
                end else begin
                    m_wait++;
                end
            end else begin
                if (m_state == 4) plan_instr();
                if (route.size() == 0) push_fetch();
                m_state = route.pop_front();
            end
        end
        #1;
        if (m_valid) begin
            check("state", int'(state), m_state);
            check("bus_err", int'(bus_err), int'(m_bus));
            check("illegal", int'(illegal), int'(m_ill));
            trace.push_back(int'(state));
            if (bus_err) bus_cnt++;
        end
    end

    // Memory responder: moc rises after a programmed number of wait cycles.
    always @(negedge CLK) begin
        if (state == 7'd3 || state == 7'd35 || state == 7'd42) begin
            moc = (wcnt >= ((state == 7'd3) ? fetch_lat : mem_lat));
            wcnt++;
        end else begin
            wcnt = 0;
            moc  = 1'b0;
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        CLR = 1'b1;
        repeat (2) @(negedge CLK);
        CLR = 1'b0;
        trace.delete();
        bus_cnt = 0;
        check("reset_state", int'(state), 0);
        check("reset_illegal", int'(illegal), 0);
        check("reset_bus_err", int'(bus_err), 0);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check_trace(input string name, input int exp[$]);
        int bad;
        bad = -1;
        if (trace.size() != exp.size()) bad = (trace.size() < exp.size()) ? trace.size() : exp.size();
        for (int i = 0; i < exp.size() && i < trace.size(); i++) begin
            if (bad < 0 && trace[i] != exp[i]) bad = i;
        end
        n_checks++;
        if (bad < 0) n_pass++;
        else $display("FAIL trace_%s: index %0d got %0d (len %0d), expected %0d (len %0d)", name, bad,
                      (bad < trace.size()) ? trace[bad] : -1, trace.size(),
                      (bad < exp.size()) ? exp[bad] : -1, exp.size());
    endtask

    task automatic run_instr(input string name, input logic [31:0] i, input logic c,
                             input int flat, input int mlat, input int exp[$]);
        ir = i; cond = c; fetch_lat = flat; mem_lat = mlat;
        do_reset();
        run(exp.size());
        check_trace(name, exp);
    endtask

    initial begin
        int q[$];

        run_instr("cond0",   32'hE3A01005, 1'b0, 1, 0, '{1, 2, 3, 3, 4, 1});
        run_instr("mov_imm", 32'hE3A01005, 1'b1, 0, 0, '{1, 2, 3, 4, 6, 1});
        check("mov_illegal", int'(illegal), 0);
        run_instr("dp_shift", 32'hE1A01002, 1'b1, 0, 0, '{1, 2, 3, 4, 7, 1});
        run_instr("bl",      32'hEB000004, 1'b1, 0, 0, '{1, 2, 3, 4, 9, 1});
        run_instr("b",       32'hEA000004, 1'b1, 0, 0, '{1, 2, 3, 4, 10, 1});
        run_instr("ldr_pre_wb", 32'hE5B12004, 1'b1, 0, 2,
                  '{1, 2, 3, 4, 33, 34, 35, 35, 35, 36, 38, 1});
        run_instr("str_post", 32'hE4812004, 1'b1, 0, 0, '{1, 2, 3, 4, 37, 40, 41, 42, 39, 1});

        // store wait that never completes: 16 cycles in 42, then abort
        q = '{1, 2, 3, 4, 37, 40, 41};
        for (int k = 0; k < 16; k++) q.push_back(42);
        q.push_back(0); q.push_back(1);
        run_instr("st_timeout", 32'hE4812004, 1'b1, 0, 1000, q);
        check("timeout_pulses", bus_cnt, 1);

        // completion on the very last permitted cycle beats the timeout
        q = '{1, 2, 3, 4, 37, 40, 41};
        for (int k = 0; k < 16; k++) q.push_back(42);
        q.push_back(39); q.push_back(1);
        run_instr("st_last_cycle", 32'hE4812004, 1'b1, 0, 15, q);
        check("last_cycle_pulses", bus_cnt, 0);

        run_instr("undef_cond0", 32'hEC000000, 1'b0, 0, 0, '{1, 2, 3, 4, 1});
        check("undef_cond0_illegal", int'(illegal), 0);
        run_instr("undef_ldc", 32'hEC000000, 1'b1, 0, 0, '{1, 2, 3, 4, 1});
        check("undef_illegal", int'(illegal), 1);
        ir = 32'hE3A01005;
        run(6);
        check("illegal_sticky", int'(illegal), 1);
        run_instr("undef_regshift", 32'hE0000010, 1'b1, 0, 0, '{1, 2, 3, 4, 1});
        check("regshift_illegal", int'(illegal), 1);
        do_reset();

        // CLR in the middle of a load wait
        run_instr("ldr_stall", 32'hE5B12004, 1'b1, 0, 1000, '{1, 2, 3, 4, 33, 34, 35, 35, 35});
        CLR = 1'b1;
        @(negedge CLK);
        check("clr_in_wait", int'(state), 0);
        CLR = 1'b0;
        run(3);
        check("after_clr_wait", int'(state), 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
